// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for the byte-serial adder.
// Ports: in_valid/in_ready + op_a/op_b/sub/cin (request), out_valid/out_ready + sum/cout/ovf (response).
// slave = adder side, master = operand source / result sink side.
interface serial_add_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport slave (
        input  in_valid, op_a, op_b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, op_a, op_b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_seq.sv
// Byte-serial NBYTES-wide add/subtract through a single 8-bit slice, LSB byte first.
// Latency: accept at edge k -> out_valid after edge k+NBYTES; issue interval NBYTES+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (slave modport of serial_add_seq_if).
module serial_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_seq_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;      // already inverted for subtraction
    logic [W-1:0]  sum_reg;
    logic          carry;
    logic          cout_reg;
    logic          ovf_reg;

    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [8:0]    slice;

    // Byte select: {idx,3'b000} is 8*idx without widening idx.
    assign a_byte = a_reg[{idx, 3'b000} +: 8];
    assign b_byte = b_reg[{idx, 3'b000} +: 8];
    assign slice  = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg    <= bus.op_a;
                        b_reg    <= bus.sub ? ~bus.op_b : bus.op_b;
                        // Subtract is A + ~B + 1, so the carry-in is forced high.
                        carry    <= bus.sub | bus.cin;
                        idx      <= '0;
                        sum_reg  <= '0;
                        cout_reg <= 1'b0;
                        ovf_reg  <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 3'b000} +: 8] <= slice[7:0];
                    carry <= slice[8];
                    if (idx == LAST) begin
                        cout_reg <= slice[8];
                        // Overflow: like-signed operands producing a differently-signed result.
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (slice[7] != a_reg[W-1]);
                        idx      <= '0;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
endmodule
